issue_select_multi: RTL and testbench



---
 rtl/issue_select_multi_pkg.sv | 60 ++++++
 rtl/issue_select_multi_if.sv | 28 ++
 rtl/issue_select_multi.sv | 186 ++++++++++++++++++
 tb/tb_issue_select_multi.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_select_multi_pkg.sv
// Shared types for the multi-port issue selector: buffer entry and issued-op payloads.
package issue_select_multi_pkg;

   localparam int unsigned BUF_SIZE_LOG = 3;
   localparam int unsigned TAG_W        = BUF_SIZE_LOG + 1;
   localparam int unsigned DATA_W       = 32;
   localparam int unsigned OP_W         = 4;
   localparam int unsigned ESO_W        = 4;

   typedef enum logic [1:0] {
      UNIT_ALU   = 2'd0,
      UNIT_MUL   = 2'd1,
      UNIT_LOAD  = 2'd2,
      UNIT_STORE = 2'd3
   } unit_t;

   typedef enum logic [1:0] {
      S_NOT_EXECUTED   = 2'd0,
      S_ADDR_GENERATED = 2'd1,
      S_EXECUTED       = 2'd2,
      S_COMMITTED      = 2'd3
   } e_state_t;

   typedef enum logic {
      EX_NORMAL   = 1'b0,
      EX_GEN_ADDR = 1'b1
   } ex_mode_t;

   // One instruction-buffer entry as seen by the selector.
   typedef struct packed {
      logic [TAG_W-1:0]  tag;
      unit_t             unit;
      logic              rwmm;
      logic [OP_W-1:0]   op;
      logic [DATA_W-1:0] vj;
      logic [DATA_W-1:0] vk;
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] pc;
      logic              j_rdy;
      logic              k_rdy;
      logic              a_rdy;
      e_state_t          e_state;
      logic [ESO_W-1:0]  number_of_early_store_ops;
   } entry_t;

   // Op held in an issue slot and presented to an execution unit.
   typedef struct packed {
      logic              is_valid;
      ex_mode_t          mode;
      unit_t             unit;
      logic              rwmm;
      logic [OP_W-1:0]   op;
      logic [DATA_W-1:0] vj;
      logic [DATA_W-1:0] vk;
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] pc;
      logic [TAG_W-1:0]  tag;
   } ex_content_t;

endpackage

// File: rtl/issue_select_multi_if.sv
// Issue-port bundle between the selector (master) and the execution units (slave).
//   issue_valid    : slot holds an issued op
//   issue_ready    : unit accepts the slot this cycle
//   issue_contents : registered op per slot
//   issue_tags     : tag of each slot
interface issue_select_multi_if #(
   parameter int unsigned ISSUE_WIDTH = 2,
   parameter int unsigned TAG_W       = 4
);
   logic [ISSUE_WIDTH-1:0]                     issue_valid;
   logic [ISSUE_WIDTH-1:0]                     issue_ready;
   issue_select_multi_pkg::ex_content_t        issue_contents [ISSUE_WIDTH];
   logic [ISSUE_WIDTH-1:0][TAG_W-1:0]          issue_tags;

   modport master (
      output issue_valid,
      output issue_contents,
      output issue_tags,
      input  issue_ready
   );

   modport slave (
      input  issue_valid,
      input  issue_contents,
      input  issue_tags,
      output issue_ready
   );
endinterface

// File: rtl/issue_select_multi.sv
// Multi-port issue selector: each cycle picks up to ISSUE_WIDTH eligible buffer
// entries, largest tag first, into registered per-port slots with valid/ready
// handshakes, and tracks in-flight entries to prevent double issue.
//   clk, rst_n : clock, async active-low reset
//   flush      : synchronous flush of slots and in-flight mask
//   entries    : current buffer contents
//   io         : issue ports (valid/ready/contents/tags)
//   pending    : per-index in-flight mask
module issue_select_multi
   import issue_select_multi_pkg::*;
#(
   parameter int unsigned BUF_SIZE     = 8,
   parameter int unsigned BUF_SIZE_LOG = 3,
   parameter int unsigned ISSUE_WIDTH  = 2
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        flush,
   input  entry_t                      entries [BUF_SIZE],
   issue_select_multi_if.master        io,
   output logic [BUF_SIZE-1:0]         pending
);

   localparam int unsigned IDX_W     = (BUF_SIZE_LOG > 0) ? BUF_SIZE_LOG : 1;
   localparam int unsigned OUT_TAG_W = BUF_SIZE_LOG + 1;
   localparam int unsigned CNT_W     = BUF_SIZE_LOG + 1;

   ex_content_t            slot_q      [ISSUE_WIDTH];
   ex_content_t            slot_d      [ISSUE_WIDTH];
   logic [IDX_W-1:0]       slot_idx_q  [ISSUE_WIDTH];
   logic [IDX_W-1:0]       slot_idx_d  [ISSUE_WIDTH];
   logic [BUF_SIZE-1:0]    pend_q;
   logic [BUF_SIZE-1:0]    pend_d;
   logic [TAG_W-1:0]       cap_tag_q   [BUF_SIZE];
   logic [TAG_W-1:0]       cap_tag_d   [BUF_SIZE];
   e_state_t               cap_state_q [BUF_SIZE];
   e_state_t               cap_state_d [BUF_SIZE];

   logic [ISSUE_WIDTH-1:0] slot_free;
   logic [ISSUE_WIDTH-1:0] slot_stall;
   logic [BUF_SIZE-1:0]    held;
   logic [BUF_SIZE-1:0]    pend_live;
   logic [BUF_SIZE-1:0]    elig;
   logic [CNT_W-1:0]       rank        [BUF_SIZE];
   logic [CNT_W-1:0]       free_ord;
   logic [ISSUE_WIDTH-1:0] sel_vld;
   logic [IDX_W-1:0]       sel_idx     [ISSUE_WIDTH];

   // Build the slot payload; address generation first for untouched memory ops.
   function automatic ex_content_t load_content(input entry_t e);
      ex_content_t c;
      c          = '0;
      c.is_valid = 1'b1;
      c.mode     = (e.e_state == S_NOT_EXECUTED &&
                    (e.unit == UNIT_LOAD || e.unit == UNIT_STORE)) ? EX_GEN_ADDR : EX_NORMAL;
      c.unit     = e.unit;
      c.rwmm     = e.rwmm;
      c.op       = e.op;
      c.vj       = e.vj;
      c.vk       = e.vk;
      c.a        = e.a;
      c.pc       = e.pc;
      c.tag      = e.tag;
      return c;
   endfunction

   // Port status: free ports may drain and refill in the same cycle.
   always_comb begin
      slot_free  = '0;
      slot_stall = '0;
      for (int p = 0; p < ISSUE_WIDTH; p++) begin
         slot_free[p]  = !slot_q[p].is_valid || io.issue_ready[p];
         slot_stall[p] = slot_q[p].is_valid && !io.issue_ready[p];
      end
   end

   // In-flight tracking and eligibility; a cleared entry is eligible immediately.
   always_comb begin
      held      = '0;
      pend_live = '0;
      elig      = '0;
      for (int i = 0; i < BUF_SIZE; i++) begin
         for (int p = 0; p < ISSUE_WIDTH; p++) begin
            if (slot_stall[p] && slot_idx_q[p] == IDX_W'(i)) held[i] = 1'b1;
         end
         pend_live[i] = pend_q[i] &&
                        (held[i] || (entries[i].tag == cap_tag_q[i] &&
                                     entries[i].e_state == cap_state_q[i]));
         elig[i] = (entries[i].tag != '0) &&
                   entries[i].j_rdy && entries[i].k_rdy && entries[i].a_rdy &&
                   (entries[i].e_state == S_NOT_EXECUTED ||
                    (entries[i].e_state == S_ADDR_GENERATED &&
                     entries[i].number_of_early_store_ops == '0)) &&
                   !pend_live[i];
      end
   end

   // Rank = number of eligible entries ahead (larger tag, or equal tag at lower index).
   always_comb begin
      for (int i = 0; i < BUF_SIZE; i++) begin
         rank[i] = '0;
         for (int j = 0; j < BUF_SIZE; j++) begin
            if (elig[j] && (entries[j].tag > entries[i].tag ||
                            (entries[j].tag == entries[i].tag && j < i))) begin
               rank[i] = rank[i] + CNT_W'(1);
            end
         end
      end
   end

   // The k-th free port (ascending) takes the eligible entry of rank k.
   always_comb begin
      free_ord = '0;
      sel_vld  = '0;
      for (int p = 0; p < ISSUE_WIDTH; p++) sel_idx[p] = '0;
      for (int p = 0; p < ISSUE_WIDTH; p++) begin
         if (slot_free[p]) begin
            for (int i = 0; i < BUF_SIZE; i++) begin
               if (elig[i] && rank[i] == free_ord) begin
                  sel_vld[p] = 1'b1;
                  sel_idx[p] = IDX_W'(i);
               end
            end
            free_ord = free_ord + CNT_W'(1);
         end
      end
   end

   // Next slot, in-flight mask and captured entry state; flush wins over everything.
   always_comb begin
      slot_d      = slot_q;
      slot_idx_d  = slot_idx_q;
      pend_d      = pend_live;
      cap_tag_d   = cap_tag_q;
      cap_state_d = cap_state_q;
      if (flush) begin
         for (int p = 0; p < ISSUE_WIDTH; p++) slot_d[p].is_valid = 1'b0;
         pend_d = '0;
      end else begin
         for (int p = 0; p < ISSUE_WIDTH; p++) begin
            if (slot_free[p]) slot_d[p].is_valid = 1'b0;
            if (sel_vld[p]) begin
               slot_d[p]                = load_content(entries[sel_idx[p]]);
               slot_idx_d[p]            = sel_idx[p];
               pend_d[sel_idx[p]]       = 1'b1;
               cap_tag_d[sel_idx[p]]    = entries[sel_idx[p]].tag;
               cap_state_d[sel_idx[p]]  = entries[sel_idx[p]].e_state;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int p = 0; p < ISSUE_WIDTH; p++) begin
            slot_q[p]     <= '0;
            slot_idx_q[p] <= '0;
         end
         pend_q <= '0;
         for (int i = 0; i < BUF_SIZE; i++) begin
            cap_tag_q[i]   <= '0;
            cap_state_q[i] <= S_NOT_EXECUTED;
         end
      end else begin
         slot_q      <= slot_d;
         slot_idx_q  <= slot_idx_d;
         pend_q      <= pend_d;
         cap_tag_q   <= cap_tag_d;
         cap_state_q <= cap_state_d;
      end
   end

   // Outputs come straight from the slot registers.
   always_comb begin
      io.issue_valid = '0;
      io.issue_tags  = '0;
      for (int p = 0; p < ISSUE_WIDTH; p++) begin
         io.issue_valid[p]    = slot_q[p].is_valid;
         io.issue_contents[p] = slot_q[p];
         io.issue_tags[p]     = OUT_TAG_W'(slot_q[p].tag);
      end
   end

   assign pending = pend_q;

endmodule

// File: tb/tb_issue_select_multi.sv
// Self-checking bench for issue_select_multi: vector table, directed corner
// sequences and randomized traffic against a sorted-queue reference model.
module tb_issue_select_multi;
   import issue_select_multi_pkg::*;

   localparam int unsigned BS = 8;
   localparam int unsigned IW = 2;

   logic            clk;
   logic            rst_n;
   logic            flush;
   entry_t          entries [BS];
   logic [BS-1:0]   pending;

   issue_select_multi_if #(.ISSUE_WIDTH(IW), .TAG_W(TAG_W)) bus ();

   issue_select_multi #(
      .BUF_SIZE     (BS),
      .BUF_SIZE_LOG (BUF_SIZE_LOG),
      .ISSUE_WIDTH  (IW)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush   (flush),
      .entries (entries),
      .io      (bus),
      .pending (pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state (current and next).
   bit          m_valid [IW];
   ex_content_t m_cont  [IW];
   int          m_idx   [IW];
   bit          m_pend  [BS];
   logic [3:0]  m_ctag  [BS];
   e_state_t    m_cstate[BS];
   bit          n_valid [IW];
   ex_content_t n_cont  [IW];
   int          n_idx   [IW];
   bit          n_pend  [BS];
   logic [3:0]  n_ctag  [BS];
   e_state_t    n_cstate[BS];

   typedef struct {
      logic [BS-1:0][3:0] tags;
      logic [BS-1:0]      rdy;
      logic [IW-1:0]      ready;
      logic               fl;
      logic [IW-1:0]      ev;
      logic [3:0]         t0;
      logic [3:0]         t1;
      logic [BS-1:0]      ep;
   } vec_t;

   vec_t vecs [14];

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit can_issue(input entry_t e);
      return (e.tag != 0) && e.j_rdy && e.k_rdy && e.a_rdy &&
             (e.e_state == S_NOT_EXECUTED ||
              (e.e_state == S_ADDR_GENERATED && e.number_of_early_store_ops == 0));
   endfunction

   function automatic ex_content_t expect_content(input entry_t e);
      ex_content_t c;
      c          = '0;
      c.is_valid = 1'b1;
      c.mode     = EX_NORMAL;
      if (e.e_state == S_NOT_EXECUTED && (e.unit == UNIT_LOAD || e.unit == UNIT_STORE))
         c.mode = EX_GEN_ADDR;
      c.unit = e.unit;
      c.rwmm = e.rwmm;
      c.op   = e.op;
      c.vj   = e.vj;
      c.vk   = e.vk;
      c.a    = e.a;
      c.pc   = e.pc;
      c.tag  = e.tag;
      return c;
   endfunction

   function automatic entry_t mk_entry(input int i, input logic [3:0] tag, input logic rdy);
      entry_t e;
      e         = '0;
      e.tag     = tag;
      e.unit    = UNIT_ALU;
      e.rwmm    = 1'(i & 1);
      e.op      = 4'(i);
      e.vj      = 32'(32'h100 + i);
      e.vk      = 32'(32'h200 + i);
      e.a       = 32'(32'h300 + i);
      e.pc      = 32'(32'h1000 + 4 * i);
      e.j_rdy   = rdy;
      e.k_rdy   = rdy;
      e.a_rdy   = rdy;
      e.e_state = S_NOT_EXECUTED;
      return e;
   endfunction

   function automatic entry_t rand_entry();
      entry_t e;
      e         = '0;
      e.tag     = 4'($urandom_range(0, 15));
      e.unit    = unit_t'(2'($urandom_range(0, 3)));
      e.rwmm    = 1'($urandom_range(0, 1));
      e.op      = 4'($urandom_range(0, 15));
      e.vj      = $urandom;
      e.vk      = $urandom;
      e.a       = $urandom;
      e.pc      = $urandom;
      e.j_rdy   = ($urandom_range(0, 4) != 0);
      e.k_rdy   = ($urandom_range(0, 4) != 0);
      e.a_rdy   = ($urandom_range(0, 4) != 0);
      e.e_state = e_state_t'(2'($urandom_range(0, 2)));
      e.number_of_early_store_ops = 4'($urandom_range(0, 1));
      return e;
   endfunction

   task automatic model_reset();
      for (int p = 0; p < IW; p++) begin
         m_valid[p] = 0; m_cont[p] = '0; m_idx[p] = 0;
      end
      for (int i = 0; i < BS; i++) begin
         m_pend[i] = 0; m_ctag[i] = '0; m_cstate[i] = S_NOT_EXECUTED;
      end
   endtask

   // Next model state from current model state and the inputs about to be clocked.
   task automatic model_next();
      int order[$];
      bit live [BS];
      n_valid = m_valid; n_cont = m_cont; n_idx = m_idx;
      n_pend  = m_pend;  n_ctag = m_ctag; n_cstate = m_cstate;
      if (flush) begin
         for (int p = 0; p < IW; p++) n_valid[p] = 0;
         for (int i = 0; i < BS; i++) n_pend[i] = 0;
         return;
      end
      for (int i = 0; i < BS; i++) begin
         bit stalled_here;
         stalled_here = 0;
         for (int p = 0; p < IW; p++)
            if (m_valid[p] && !bus.issue_ready[p] && m_idx[p] == i) stalled_here = 1;
         live[i] = m_pend[i] &&
                   (stalled_here || (entries[i].tag == m_ctag[i] && entries[i].e_state == m_cstate[i]));
         n_pend[i] = live[i];
      end
      // Descending-tag list; equal tags keep ascending index order.
      for (int i = 0; i < BS; i++) begin
         if (can_issue(entries[i]) && !live[i]) begin
            int pos;
            pos = order.size();
            for (int k = 0; k < order.size(); k++) begin
               if (entries[order[k]].tag < entries[i].tag) begin
                  pos = k;
                  break;
               end
            end
            order.insert(pos, i);
         end
      end
      for (int p = 0; p < IW; p++) begin
         if (!m_valid[p] || bus.issue_ready[p]) begin
            if (order.size() > 0) begin
               int k;
               k = order.pop_front();
               n_valid[p] = 1; n_cont[p] = expect_content(entries[k]); n_idx[p] = k;
               n_pend[k] = 1; n_ctag[k] = entries[k].tag; n_cstate[k] = entries[k].e_state;
            end else begin
               n_valid[p] = 0;
            end
         end
      end
   endtask

   task automatic model_check();
      logic [BS-1:0] ep;
      for (int p = 0; p < IW; p++) begin
         chk($sformatf("model_valid[%0d]", p), 256'(bus.issue_valid[p]), 256'(m_valid[p]));
         if (m_valid[p]) begin
            chk($sformatf("model_content[%0d]", p), 256'(bus.issue_contents[p]), 256'(m_cont[p]));
            chk($sformatf("model_tag[%0d]", p), 256'(bus.issue_tags[p]), 256'(m_cont[p].tag));
         end else begin
            chk($sformatf("model_isvalid[%0d]", p), 256'(bus.issue_contents[p].is_valid), 256'(0));
         end
      end
      for (int i = 0; i < BS; i++) ep[i] = m_pend[i];
      chk("model_pending", 256'(pending), 256'(ep));
   endtask

   // One clock: predict, clock, compare one time unit after the edge.
   task automatic step();
      model_next();
      @(posedge clk);
      #1;
      m_valid = n_valid; m_cont = n_cont; m_idx = n_idx;
      m_pend  = n_pend;  m_ctag = n_ctag; m_cstate = n_cstate;
      model_check();
   endtask

   initial begin
      vecs[0]  = '{32'h00000735, 8'h07, 2'b00, 1'b0, 2'b11, 4'd7, 4'd5, 8'h05};
      vecs[1]  = '{32'h00000735, 8'h07, 2'b00, 1'b0, 2'b11, 4'd7, 4'd5, 8'h05};
      vecs[2]  = '{32'h00000735, 8'h07, 2'b01, 1'b0, 2'b11, 4'd3, 4'd5, 8'h07};
      vecs[3]  = '{32'h00000735, 8'h07, 2'b11, 1'b0, 2'b00, 4'd0, 4'd0, 8'h07};
      vecs[4]  = '{32'h00000795, 8'h07, 2'b00, 1'b0, 2'b01, 4'd9, 4'd0, 8'h07};
      vecs[5]  = '{32'h00000795, 8'h07, 2'b00, 1'b1, 2'b00, 4'd0, 4'd0, 8'h00};
      vecs[6]  = '{32'h00000795, 8'h07, 2'b00, 1'b0, 2'b11, 4'd9, 4'd7, 8'h06};
      vecs[7]  = '{32'h00000795, 8'h07, 2'b10, 1'b0, 2'b11, 4'd9, 4'd5, 8'h07};
      vecs[8]  = '{32'h00000795, 8'h07, 2'b10, 1'b0, 2'b01, 4'd9, 4'd0, 8'h07};
      vecs[9]  = '{32'h00000795, 8'h07, 2'b11, 1'b1, 2'b00, 4'd0, 4'd0, 8'h00};
      vecs[10] = '{32'h00005795, 8'h0F, 2'b00, 1'b0, 2'b11, 4'd9, 4'd7, 8'h06};
      vecs[11] = '{32'h00005795, 8'h0F, 2'b11, 1'b0, 2'b11, 4'd5, 4'd5, 8'h0F};
      vecs[12] = '{32'h00005795, 8'h0F, 2'b11, 1'b0, 2'b00, 4'd0, 4'd0, 8'h0F};
      vecs[13] = '{32'h000F5795, 8'h2F, 2'b11, 1'b0, 2'b00, 4'd0, 4'd0, 8'h0F};

      rst_n = 1'b0;
      flush = 1'b0;
      bus.issue_ready = '0;
      for (int i = 0; i < BS; i++) entries[i] = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      for (int p = 0; p < IW; p++) begin
         chk($sformatf("reset_valid[%0d]", p), 256'(bus.issue_valid[p]), 256'(0));
         chk($sformatf("reset_content[%0d]", p), 256'(bus.issue_contents[p]), 256'(0));
         chk($sformatf("reset_tag[%0d]", p), 256'(bus.issue_tags[p]), 256'(0));
      end
      chk("reset_pending", 256'(pending), 256'(0));
      rst_n = 1'b1;

      // Vector table: ranking, stalls, pending clear on rewrite, flush, tie-break.
      for (int r = 0; r < 14; r++) begin
         for (int i = 0; i < BS; i++) entries[i] = mk_entry(i, vecs[r].tags[i], vecs[r].rdy[i]);
         flush = vecs[r].fl;
         bus.issue_ready = vecs[r].ready;
         step();
         chk($sformatf("vec%0d_valid", r), 256'(bus.issue_valid), 256'(vecs[r].ev));
         if (vecs[r].ev[0]) chk($sformatf("vec%0d_tag0", r), 256'(bus.issue_tags[0]), 256'(vecs[r].t0));
         if (vecs[r].ev[1]) chk($sformatf("vec%0d_tag1", r), 256'(bus.issue_tags[1]), 256'(vecs[r].t1));
         chk($sformatf("vec%0d_pending", r), 256'(pending), 256'(vecs[r].ep));
      end

      // Port0 stalled on tag 6 for four cycles while port1 keeps draining.
      flush = 1'b1;
      step();
      flush = 1'b0;
      for (int i = 0; i < BS; i++) entries[i] = mk_entry(i, 4'd0, 1'b1);
      entries[0] = mk_entry(0, 4'd6, 1'b1);
      entries[1] = mk_entry(1, 4'd4, 1'b1);
      entries[2] = mk_entry(2, 4'd3, 1'b1);
      entries[3] = mk_entry(3, 4'd2, 1'b1);
      bus.issue_ready = 2'b00;
      step();
      chk("stall_pre_tag0", 256'(bus.issue_tags[0]), 256'(6));
      chk("stall_pre_tag1", 256'(bus.issue_tags[1]), 256'(4));
      bus.issue_ready = 2'b10;
      for (int c = 0; c < 4; c++) begin
         logic [3:0] exp_t1;
         exp_t1 = (c == 0) ? 4'd3 : 4'd2;
         step();
         chk($sformatf("stall%0d_valid0", c), 256'(bus.issue_valid[0]), 256'(1));
         chk($sformatf("stall%0d_content0", c), 256'(bus.issue_contents[0]), 256'(expect_content(entries[0])));
         chk($sformatf("stall%0d_valid1", c), 256'(bus.issue_valid[1]), 256'(c < 2));
         if (c < 2) chk($sformatf("stall%0d_tag1", c), 256'(bus.issue_tags[1]), 256'(exp_t1));
      end

      // LOAD: address generation, blocked by early stores, then normal reissue.
      flush = 1'b1;
      step();
      flush = 1'b0;
      for (int i = 0; i < BS; i++) entries[i] = mk_entry(i, 4'd0, 1'b1);
      entries[5] = mk_entry(5, 4'd4, 1'b1);
      entries[5].unit = UNIT_LOAD;
      bus.issue_ready = 2'b11;
      step();
      chk("ld_valid0", 256'(bus.issue_valid[0]), 256'(1));
      chk("ld_tag0", 256'(bus.issue_tags[0]), 256'(4));
      chk("ld_mode_gen", 256'(bus.issue_contents[0].mode), 256'(EX_GEN_ADDR));
      chk("ld_pending", 256'(pending), 256'(8'h20));
      entries[5].e_state = S_ADDR_GENERATED;
      entries[5].number_of_early_store_ops = 4'd1;
      for (int c = 0; c < 2; c++) begin
         step();
         chk($sformatf("ld_blocked%0d_valid", c), 256'(bus.issue_valid), 256'(0));
         chk($sformatf("ld_blocked%0d_pending", c), 256'(pending), 256'(0));
      end
      entries[5].number_of_early_store_ops = 4'd0;
      step();
      chk("ld_re_valid0", 256'(bus.issue_valid[0]), 256'(1));
      chk("ld_re_mode", 256'(bus.issue_contents[0].mode), 256'(EX_NORMAL));
      chk("ld_re_pending", 256'(pending), 256'(8'h20));

      // Asynchronous reset mid-cycle with a stalled slot.
      bus.issue_ready = 2'b00;
      step();
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", 256'(bus.issue_valid), 256'(0));
      chk("arst_content0", 256'(bus.issue_contents[0]), 256'(0));
      chk("arst_pending", 256'(pending), 256'(0));
      model_reset();
      @(posedge clk);
      #1;
      chk("arst_hold_valid", 256'(bus.issue_valid), 256'(0));
      rst_n = 1'b1;
      bus.issue_ready = 2'b11;
      step();
      chk("arst_first_valid0", 256'(bus.issue_valid[0]), 256'(1));
      chk("arst_first_tag0", 256'(bus.issue_tags[0]), 256'(4));

      // Randomized traffic against the model.
      for (int i = 0; i < BS; i++) entries[i] = rand_entry();
      for (int cyc = 0; cyc < 800; cyc++) begin
         for (int i = 0; i < BS; i++) begin
            if ($urandom_range(0, 5) == 0) entries[i] = rand_entry();
            else if ($urandom_range(0, 7) == 0) entries[i].e_state = e_state_t'(2'($urandom_range(0, 3)));
            else if ($urandom_range(0, 9) == 0) entries[i].number_of_early_store_ops = 4'd0;
         end
         for (int p = 0; p < IW; p++) bus.issue_ready[p] = ($urandom_range(0, 3) != 0);
         flush = ($urandom_range(0, 31) == 0);
         step();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
